// File: rtl/fir_coef_sequencer.sv
// Coefficient loader and sample streamer for the transposed-form FIR filter.
// Shifts a local coefficient bank into the filter, flushes it, then streams samples with an aligned valid flag.
module fir_coef_sequencer #(
    parameter int W1    = 9,
    parameter int L     = 4,
    parameter int AW    = 2,
    parameter int Mpipe = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cw_en,
    input  logic [AW-1:0]        cw_addr,
    input  logic signed [W1-1:0] cw_data,
    input  logic                 start,
    input  logic                 x_valid,
    input  logic signed [W1-1:0] x_data,
    output logic                 x_ready,
    output logic                 Load_x,
    output logic signed [W1-1:0] c_out,
    output logic signed [W1-1:0] x_out,
    output logic                 busy,
    output logic                 done,
    output logic                 y_valid
);

    localparam int D    = Mpipe + 2;
    localparam int FLEN = L + Mpipe;
    localparam int FW   = $clog2(FLEN);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t               state_q;
    logic signed [W1-1:0] bank_q [L];
    logic [AW-1:0]        k_q;
    logic [AW-1:0]        k_d;
    logic [FW-1:0]        f_q;
    logic [D-1:0]         vpipe_q;

    logic bank_we;
    logic go_load;
    logic accept;

    assign k_d     = k_q + AW'(1);
    assign bank_we = cw_en && (32'(cw_addr) < L) && (state_q != LOAD);
    assign go_load = start && ((state_q == IDLE) || (state_q == RUN));
    // A start in RUN wins over a sample offered in the same cycle.
    assign accept  = x_valid && x_ready && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_q[cw_addr] <= cw_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            f_q     <= '0;
            vpipe_q <= '0;
            Load_x  <= 1'b1;
            c_out   <= '0;
            x_out   <= '0;
            x_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            vpipe_q <= {vpipe_q[D-2:0], accept};
            y_valid <= vpipe_q[D-1];
            if (go_load) begin
                // Any samples still in flight belong to the old coefficient set.
                state_q <= LOAD;
                k_q     <= '0;
                vpipe_q <= '0;
                y_valid <= 1'b0;
                Load_x  <= 1'b0;
                c_out   <= bank_q[0];
                x_out   <= '0;
                x_ready <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        Load_x <= 1'b1;
                        c_out  <= '0;
                        x_out  <= '0;
                    end
                    LOAD: begin
                        if (k_q == AW'(L - 1)) begin
                            state_q <= FLUSH;
                            f_q     <= '0;
                            Load_x  <= 1'b1;
                            c_out   <= '0;
                            x_out   <= '0;
                        end else begin
                            k_q   <= k_d;
                            c_out <= bank_q[k_d];
                        end
                    end
                    FLUSH: begin
                        if (f_q == FW'(FLEN - 1)) begin
                            state_q <= RUN;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            x_ready <= 1'b1;
                        end else begin
                            f_q <= f_q + FW'(1);
                        end
                    end
                    RUN: begin
                        x_out <= x_valid ? x_data : '0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
